mac_tx_arbiter: RTL and testbench

- Shares the single SimpleMac byte-stream TX write port between two frame sources.
  - Source 0: sample Packetizer, high-rate stream.
  - Source 1: control/management frame generator (ARP/status replies).
- Grants whole frames round-robin, forwards bytes with one registered stage, and honours MAC back-pressure.
- Aborts stalled or oversized frames with tx_err so the MAC never hangs.
- Sits between the packet sources and SimpleMac in the clk_50 domain.

---
 rtl/mac_tx_arbiter_pkg.sv | 23 ++
 rtl/mac_tx_arbiter_if.sv | 44 ++++
 rtl/mac_tx_arbiter_watchdog.sv | 51 +++++
 rtl/mac_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_tx_arbiter_pkg.sv
// Shared types and constants for the two-source MAC TX arbiter.
package mac_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } arb_state_t;

  localparam int MAX_FRAME_BYTES_DEF = 1514;
  localparam int TIMEOUT_CYCLES_DEF  = 1024;
  localparam int CNT_W_DEF           = 16;

  // Data byte carried by the single-byte abort marker sent to the MAC.
  localparam logic [7:0] ABORT_FILL = 8'h00;

  // Width able to hold the value max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Byte-stream handshake bundle: two frame sources plus the SimpleMac TX write port.
interface mac_tx_arbiter_if;

  logic       s0_req;
  logic [7:0] s0_data;
  logic       s0_valid;
  logic       s0_sop;
  logic       s0_eop;
  logic       s0_ready;

  logic       s1_req;
  logic [7:0] s1_data;
  logic       s1_valid;
  logic       s1_sop;
  logic       s1_eop;
  logic       s1_ready;

  logic [7:0] tx_data;
  logic       tx_sop;
  logic       tx_eop;
  logic       tx_err;
  logic       tx_wren;
  logic       tx_rdy;
  logic       tx_a_full;

  // Arbiter side.
  modport slave (
    input  s0_req, s0_data, s0_valid, s0_sop, s0_eop,
    input  s1_req, s1_data, s1_valid, s1_sop, s1_eop,
    output s0_ready, s1_ready,
    output tx_data, tx_sop, tx_eop, tx_err, tx_wren,
    input  tx_rdy, tx_a_full
  );

  // Environment side: the frame sources and the MAC.
  modport master (
    output s0_req, s0_data, s0_valid, s0_sop, s0_eop,
    output s1_req, s1_data, s1_valid, s1_sop, s1_eop,
    input  s0_ready, s1_ready,
    input  tx_data, tx_sop, tx_eop, tx_err, tx_wren,
    output tx_rdy, tx_a_full
  );

endinterface

// File: rtl/mac_tx_arbiter_watchdog.sv
// Per-grant frame watchdog: counts idle cycles and accepted bytes of the
// granted source and flags stall timeout and oversize conditions.
module mac_tx_arbiter_watchdog
  import mac_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,     // no grant active: restart both counters
  input  logic active,    // a source currently holds the grant
  input  logic valid,     // granted source valid
  input  logic accept,    // MAC can take a byte
  input  logic xfer,      // byte accepted from granted source
  output logic timeout,   // idle limit reached
  output logic oversize,  // MAX_FRAME_BYTES already accepted
  output logic first      // no byte accepted yet in this grant
);

  localparam int IW = cnt_width(TIMEOUT_CYCLES);
  localparam int BW = cnt_width(MAX_FRAME_BYTES);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BYTE_LIMIT = BW'(MAX_FRAME_BYTES);

  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] byte_cnt;

  // Idle and byte counters for the frame under grant.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      idle_cnt <= '0;
      byte_cnt <= '0;
    end else if (xfer) begin
      idle_cnt <= '0;
      if (!oversize) byte_cnt <= byte_cnt + BW'(1);
    end else if (active && !valid && accept && !timeout) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign timeout  = (idle_cnt == IDLE_LIMIT);
  assign oversize = (byte_cnt == BYTE_LIMIT);
  assign first    = (byte_cnt == '0);

endmodule

// File: rtl/mac_tx_arbiter.sv
// Round-robin whole-frame arbiter in front of the SimpleMac TX write port,
// with one registered output stage and stall/oversize abort.
module mac_tx_arbiter
  import mac_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  mac_tx_arbiter_if.slave      bus,
  output logic                 tx_clk,
  output logic                 busy,
  output logic [CNT_W-1:0]     frames0,
  output logic [CNT_W-1:0]     frames1,
  output logic [CNT_W-1:0]     aborts
);

  arb_state_t state, state_nxt;

  logic       cur;         // source holding (or last holding) the grant
  logic       last_grant;  // source whose frame finished most recently
  logic       accept;
  logic       in_grant;
  logic       xfer;
  logic       sel_valid, sel_sop, sel_eop;
  logic [7:0] sel_data;
  logic       fwd, emit_abort, frame_done;
  logic       timeout, oversize, first;

  logic [7:0] tx_data_q;
  logic       tx_sop_q, tx_eop_q, tx_err_q, tx_wren_q;

  assign tx_clk   = clk;
  assign accept   = !bus.tx_a_full && bus.tx_rdy;
  assign in_grant = (state == GRANT0) || (state == GRANT1);
  assign busy     = (state != IDLE);

  assign bus.s0_ready = accept && (state == GRANT0);
  assign bus.s1_ready = accept && (state == GRANT1);

  assign sel_valid = cur ? bus.s1_valid : bus.s0_valid;
  assign sel_sop   = cur ? bus.s1_sop   : bus.s0_sop;
  assign sel_eop   = cur ? bus.s1_eop   : bus.s0_eop;
  assign sel_data  = cur ? bus.s1_data  : bus.s0_data;
  assign xfer      = in_grant && accept && sel_valid;

  mac_tx_arbiter_watchdog #(
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .MAX_FRAME_BYTES (MAX_FRAME_BYTES)
  ) tx_frame_watchdog (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (state == IDLE),
    .active   (in_grant),
    .valid    (sel_valid),
    .accept   (accept),
    .xfer     (xfer),
    .timeout  (timeout),
    .oversize (oversize),
    .first    (first)
  );

  // Next-state and per-cycle actions of the grant FSM.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    fwd        = 1'b0;
    emit_abort = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s0_req && (!bus.s1_req || last_grant)) state_nxt = GRANT0;
        else if (bus.s1_req)                           state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          // A byte past the size limit or a restart mid-frame is dropped
          // and the frame is closed with the abort marker instead.
          if (oversize || (!first && sel_sop)) begin
            state_nxt = ABORT;
          end else begin
            fwd = 1'b1;
            if (sel_eop) begin
              frame_done = 1'b1;
              state_nxt  = IDLE;
            end
          end
        end else if (timeout) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        if (accept) begin
          emit_abort = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant bookkeeping; last_grant resets to 1 so source 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (state == IDLE && state_nxt == GRANT0) cur <= 1'b0;
      if (state == IDLE && state_nxt == GRANT1) cur <= 1'b1;
      if (frame_done || emit_abort)             last_grant <= cur;
    end
  end

  // Registered output stage toward the MAC; the first byte of a grant always
  // carries sop even when the source omitted it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data_q <= '0;
      tx_sop_q  <= 1'b0;
      tx_eop_q  <= 1'b0;
      tx_err_q  <= 1'b0;
      tx_wren_q <= 1'b0;
    end else begin
      tx_wren_q <= fwd || emit_abort;
      if (fwd) begin
        tx_data_q <= sel_data;
        tx_sop_q  <= first;
        tx_eop_q  <= sel_eop;
        tx_err_q  <= 1'b0;
      end else if (emit_abort) begin
        tx_data_q <= ABORT_FILL;
        tx_sop_q  <= first;
        tx_eop_q  <= 1'b1;
        tx_err_q  <= 1'b1;
      end
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_sop  = tx_sop_q;
  assign bus.tx_eop  = tx_eop_q;
  assign bus.tx_err  = tx_err_q;
  assign bus.tx_wren = tx_wren_q;

  // Completed and aborted frame counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frames0 <= '0;
      frames1 <= '0;
      aborts  <= '0;
    end else begin
      if (frame_done && !cur) frames0 <= frames0 + CNT_W'(1);
      if (frame_done &&  cur) frames1 <= frames1 + CNT_W'(1);
      if (emit_abort)         aborts  <= aborts  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: frame transfer, round-robin, back-pressure,
// stall timeout, oversize abort and asynchronous reset.
module tb_mac_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tx_clk, busy;
  logic [15:0] frames0, frames1, aborts;

  mac_tx_arbiter_if bus ();

  mac_tx_arbiter dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .tx_clk  (tx_clk),
    .busy    (busy),
    .frames0 (frames0),
    .frames1 (frames1),
    .aborts  (aborts)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
    int         cyc;
  } cap_t;

  cap_t cap[$];       // every MAC write strobe
  int   xfer_cyc[$];  // cycle of every accepted source byte

  always @(negedge clk)
    if (rstn && bus.tx_wren)
      cap.push_back('{bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_err, cyc});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int src, input logic req, input logic valid,
                       input logic sop, input logic eop, input logic [7:0] data);
    if (src == 0) begin
      bus.s0_req = req; bus.s0_valid = valid; bus.s0_sop = sop;
      bus.s0_eop = eop; bus.s0_data = data;
    end else begin
      bus.s1_req = req; bus.s1_valid = valid; bus.s1_sop = sop;
      bus.s1_eop = eop; bus.s1_data = data;
    end
  endtask

  function automatic logic ready_of(input int src);
    return (src == 0) ? bus.s0_ready : bus.s1_ready;
  endfunction

  // Sends len bytes base, base+step, ...; req is held for the whole frame.
  task automatic send_frame(input int src, input int len, input logic [7:0] base,
                            input logic [7:0] step, input bit omit_sop, input bit omit_eop);
    logic [7:0] d;
    bit ok;
    d = base;
    for (int i = 0; i < len; i++) begin
      drive(src, 1'b1, 1'b1, (i == 0) && !omit_sop, (i == len - 1) && !omit_eop, d);
      ok = 1'b0;
      for (int w = 0; w < 5000; w++) begin
        @(negedge clk);
        if (ready_of(src)) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        check($sformatf("src%0d_ready_wait", src), 32'd0, 32'd1);
        break;
      end
      xfer_cyc.push_back(cyc);
      @(posedge clk); #1;
      d = d + step;
    end
    drive(src, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.tx_rdy    = 1'b1;
    bus.tx_a_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    cap.delete();
    xfer_cyc.delete();
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] exp2 [12];
    int stall_ready, stall_wren, max_gap, bad, gap;

    // ---------------- reset state ----------------
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.tx_rdy    = 1'b1;
    bus.tx_a_full = 1'b0;
    #1;
    check("rst_busy",     busy,         0);
    check("rst_tx_wren",  bus.tx_wren,  0);
    check("rst_s0_ready", bus.s0_ready, 0);
    check("rst_frames0",  frames0,      0);
    check("rst_aborts",   aborts,       0);
    do_reset();

    // ---------------- T1: single 4-byte frame from s0 ----------------
    send_frame(0, 4, 8'hAA, 8'h11, 1'b0, 1'b0);
    settle();
    check("t1_count", cap.size(), 4);
    for (int i = 0; i < cap.size() && i < 4; i++) begin
      check($sformatf("t1_data%0d", i), cap[i].data, 8'hAA + 8'(i * 8'h11));
      check($sformatf("t1_sop_eop%0d", i), {cap[i].sop, cap[i].eop, cap[i].err},
            {(i == 0), (i == 3), 1'b0});
      check($sformatf("t1_latency%0d", i), cap[i].cyc, xfer_cyc[i] + 1);
    end
    check("t1_frames0", frames0, 1);
    check("t1_frames1", frames1, 0);
    check("t1_busy",    busy,    0);

    // ---------------- T2: both sources, alternating grants ----------------
    do_reset();
    exp2 = '{8'h10, 8'h11, 8'h12, 8'h80, 8'h81, 8'h82,
             8'h20, 8'h21, 8'h22, 8'h90, 8'h91, 8'h92};
    fork
      begin
        send_frame(0, 3, 8'h10, 8'h01, 1'b0, 1'b0);
        send_frame(0, 3, 8'h20, 8'h01, 1'b0, 1'b0);
      end
      begin
        send_frame(1, 3, 8'h80, 8'h01, 1'b0, 1'b0);
        send_frame(1, 3, 8'h90, 8'h01, 1'b0, 1'b0);
      end
    join
    settle();
    check("t2_count", cap.size(), 12);
    for (int i = 0; i < cap.size() && i < 12; i++) begin
      check($sformatf("t2_data%0d", i), cap[i].data, exp2[i]);
      check($sformatf("t2_sop_eop%0d", i), {cap[i].sop, cap[i].eop},
            {(i % 3 == 0), (i % 3 == 2)});
    end
    check("t2_frames0", frames0, 2);
    check("t2_frames1", frames1, 2);

    // ---------------- T3: MAC almost-full stall mid-frame ----------------
    do_reset();
    stall_ready = 0;
    stall_wren  = 0;
    fork
      send_frame(0, 6, 8'h40, 8'h01, 1'b0, 1'b0);
      begin
        for (int w = 0; w < 200 && xfer_cyc.size() < 2; w++) @(negedge clk);
        @(posedge clk); #1 bus.tx_a_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (bus.s0_ready) stall_ready++;
          // The first stall cycle may still show the byte accepted just before.
          if (i > 0 && bus.tx_wren) stall_wren++;
        end
        @(posedge clk); #1 bus.tx_a_full = 1'b0;
      end
    join
    settle();
    check("t3_ready_during_stall", stall_ready, 0);
    check("t3_wren_during_stall",  stall_wren,  0);
    max_gap = 0;
    for (int i = 1; i < xfer_cyc.size(); i++) begin
      gap = xfer_cyc[i] - xfer_cyc[i-1];
      if (gap > max_gap) max_gap = gap;
    end
    check("t3_stall_seen", max_gap >= 5, 1);
    check("t3_count", cap.size(), 6);
    bad = 0;
    for (int i = 0; i < cap.size() && i < 6; i++)
      if (cap[i].data != 8'(8'h40 + i) || cap[i].sop != (i == 0) ||
          cap[i].eop != (i == 5) || cap[i].err) bad++;
    check("t3_frame_intact", bad, 0);
    check("t3_aborts",  aborts,  0);
    check("t3_frames0", frames0, 1);

    // ---------------- T4: s1 stalls after sop, timeout abort ----------------
    do_reset();
    fork
      send_frame(1, 1, 8'h55, 8'h01, 1'b0, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #1;
        send_frame(0, 3, 8'h30, 8'h01, 1'b0, 1'b0);
      end
    join
    settle();
    check("t4_count", cap.size(), 5);
    if (cap.size() >= 5) begin
      check("t4_first_byte", {cap[0].data, cap[0].sop, cap[0].eop, cap[0].err},
            {8'h55, 1'b1, 1'b0, 1'b0});
      check("t4_abort_byte", {cap[1].data, cap[1].eop, cap[1].err},
            {8'h00, 1'b1, 1'b1});
      // 1024 idle cycles, then the abort decision, ABORT state and output register.
      gap = cap[1].cyc - cap[0].cyc;
      check("t4_abort_delay", (gap >= 1025) && (gap <= 1027), 1);
      check("t4_s0_frame", {cap[2].data, cap[3].data, cap[4].data, cap[2].sop, cap[4].eop},
            {8'h30, 8'h31, 8'h32, 1'b1, 1'b1});
    end
    check("t4_aborts",  aborts,  1);
    check("t4_frames0", frames0, 1);
    check("t4_frames1", frames1, 0);

    // ---------------- T5: oversize frame ----------------
    do_reset();
    send_frame(0, 1515, 8'h00, 8'h01, 1'b0, 1'b1);
    settle();
    check("t5_count", cap.size(), 1515);
    bad = 0;
    for (int i = 0; i < cap.size() && i < 1514; i++)
      if (cap[i].data != 8'(i) || cap[i].sop != (i == 0) || cap[i].eop || cap[i].err) bad++;
    check("t5_forwarded_bytes", bad, 0);
    if (cap.size() == 1515)
      check("t5_abort_byte", {cap[1514].data, cap[1514].eop, cap[1514].err},
            {8'h00, 1'b1, 1'b1});
    check("t5_aborts",  aborts,  1);
    check("t5_frames0", frames0, 0);
    check("t5_busy",    busy,    0);

    // ---------------- T6: reset mid-frame, then recovery ----------------
    do_reset();
    send_frame(0, 2, 8'h70, 8'h01, 1'b0, 1'b0);
    send_frame(0, 3, 8'h60, 8'h01, 1'b0, 1'b1);
    check("t6_busy_before_rst", busy,        1);
    check("t6_wren_before_rst", bus.tx_wren, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_outputs",
          {bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_err, bus.tx_wren,
           bus.s0_ready, bus.s1_ready, busy}, 0);
    check("t6_rst_frames0", frames0, 0);
    check("t6_rst_aborts",  aborts,  0);
    @(posedge clk);
    #1 rstn = 1'b1;
    cap.delete();
    xfer_cyc.delete();
    send_frame(1, 2, 8'hC0, 8'h01, 1'b1, 1'b0);  // first byte without sop
    send_frame(0, 1, 8'hE0, 8'h01, 1'b0, 1'b0);  // single-byte frame
    settle();
    check("t6_count", cap.size(), 3);
    if (cap.size() >= 3) begin
      check("t6_forced_sop", {cap[0].data, cap[0].sop, cap[0].eop}, {8'hC0, 1'b1, 1'b0});
      check("t6_s1_last",    {cap[1].data, cap[1].sop, cap[1].eop}, {8'hC1, 1'b0, 1'b1});
      check("t6_single",     {cap[2].data, cap[2].sop, cap[2].eop, cap[2].err},
            {8'hE0, 1'b1, 1'b1, 1'b0});
    end
    check("t6_frames1", frames1, 1);
    check("t6_frames0", frames0, 1);
    check("t6_aborts",  aborts,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
